// File: rtl/smult_pkg.sv
// Shared constants, FSM state type and helpers for the
// serial FP16 scalar-by-vector multiplier.
package smult_pkg;

  localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;
  localparam logic [15:0] FP16_MAX_NEG = 16'hFBFF;
  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [14:0] FP16_INF_MAG = 15'h7C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [15:0] fp16_sat(
    input logic sgn
  );
    return sgn ? FP16_MAX_NEG : FP16_MAX_POS;
  endfunction

endpackage

// File: rtl/smult_vec_seq_vmult.sv
// Combinational FP16 multiplier, round-to-nearest-even,
// subnormal in/out; overflow flags finite*finite -> inf.
module smult_vec_seq_vmult
  import smult_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] product_o,
  output logic        overflow_o
);

  logic        sgn;
  logic [4:0]  ea, eb, ea_e, eb_e;
  logic [9:0]  fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_zero, b_zero;
  logic [10:0] ma, mb;
  logic [21:0] mp, mn, ms;
  logic [4:0]  lz, sh;
  logic [7:0]  e_n, nsh;
  logic [43:0] wide;
  logic        sub, big, lost;
  logic        g, st, rnd;
  logic [4:0]  efld;
  logic [14:0] mag;
  logic        ovf;

  assign sgn = a_i[15] ^ b_i[15];
  assign ea  = a_i[14:10];
  assign eb  = b_i[14:10];
  assign fa  = a_i[9:0];
  assign fb  = b_i[9:0];

  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea) & ~(|fa);
  assign b_zero = ~(|eb) & ~(|fb);

  // subnormals carry no hidden bit but use exponent 1
  assign ma   = {|ea, fa};
  assign mb   = {|eb, fb};
  assign ea_e = (|ea) ? ea : 5'd1;
  assign eb_e = (|eb) ? eb : 5'd1;
  assign mp   = 22'(ma) * 22'(mb);

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 22; i++) begin
      if (mp[i]) lz = 5'(21 - i);
    end
  end

  assign mn  = mp << lz;
  assign e_n = {3'b0, ea_e} + {3'b0, eb_e}
             - 8'd14 - {3'b0, lz};

  assign sub = e_n[7] | (e_n == 8'd0);
  assign big = ~e_n[7] & (e_n >= 8'd31);
  assign nsh = 8'd1 - e_n;

  always_comb begin
    sh = 5'd0;
    if (sub) begin
      sh = (nsh > 8'd23) ? 5'd23 : nsh[4:0];
    end
  end

  assign wide = {mn, 22'b0} >> sh;
  assign ms   = wide[43:22];
  assign lost = |wide[21:0];

  // a denormalising shift always clears the hidden bit
  assign efld = ms[21] ? e_n[4:0] : 5'd0;
  assign g    = ms[10];
  assign st   = (|ms[9:0]) | lost;
  assign rnd  = g & (st | ms[11]);
  assign mag  = {efld, ms[20:11]} + {14'b0, rnd};
  assign ovf  = big | (&mag[14:10]);

  always_comb begin
    product_o  = {sgn, mag};
    overflow_o = 1'b0;
    if (a_nan | b_nan | (a_inf & b_zero)
        | (b_inf & a_zero)) begin
      product_o = FP16_QNAN;
    end else if (a_inf | b_inf) begin
      product_o = {sgn, FP16_INF_MAG};
    end else if (a_zero | b_zero) begin
      product_o = {sgn, 15'b0};
    end else if (ovf) begin
      product_o  = {sgn, FP16_INF_MAG};
      overflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/smult_vec_seq.sv
// Serial FP16 scalar x vector multiplier: reads elements from
// the VRF, scales them and emits write-backs at 1 elem/cycle.
module smult_vec_seq
  import smult_pkg::*;
#(
  parameter int N_ELEM = 16,
  parameter bit SAT_EN = 1'b0,
  localparam int IDX_W =
    (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [15:0]      scalar,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [15:0]      vecin,
  output logic [15:0]      product,
  output logic [IDX_W-1:0] wr_idx,
  output logic             write,
  output logic             ov_elem,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_ELEM - 1);

  state_e           state_q;
  logic [15:0]      scalar_q;
  logic [IDX_W-1:0] rd_q, ridx_q, wr_q;
  logic             rvalid_q;
  logic [15:0]      prod_q;
  logic             write_q, ov_q, v_q;
  logic             busy_q, done_q;

  logic [15:0]      mul_res, res_d;
  logic             mul_ov, wr_en;

  smult_vec_seq_vmult u_vmult (
    .a_i        (scalar_q),
    .b_i        (vecin),
    .product_o  (mul_res),
    .overflow_o (mul_ov)
  );

  assign res_d = (SAT_EN && mul_ov)
               ? fp16_sat(mul_res[15]) : mul_res;

  // an abort (start low) also kills the in-flight element
  assign wr_en = rvalid_q & start;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      scalar_q <= '0;
      rd_q     <= '0;
      ridx_q   <= '0;
      rvalid_q <= 1'b0;
      wr_q     <= '0;
      prod_q   <= '0;
      write_q  <= 1'b0;
      ov_q     <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      write_q  <= 1'b0;
      ov_q     <= 1'b0;
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            scalar_q <= scalar;
            v_q      <= 1'b0;
            rd_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (!start) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rvalid_q <= 1'b1;
            ridx_q   <= rd_q;
            if (rd_q == LAST) begin
              state_q <= DRAIN;
            end else begin
              rd_q <= rd_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!start) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (wr_en) begin
        write_q <= 1'b1;
        wr_q    <= ridx_q;
        prod_q  <= res_d;
        ov_q    <= mul_ov;
        v_q     <= v_q | mul_ov;
      end
    end
  end

  assign rd_idx  = rd_q;
  assign wr_idx  = wr_q;
  assign product = prod_q;
  assign write   = write_q;
  assign ov_elem = ov_q;
  assign V       = v_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/smult_vec_seq.md
Name: smult_vec_seq

Overview:
Parametrised serial scalar×vector multiplier for FP16 (IEEE half-precision) vectors of N_ELEM elements, on a single clock.
- Drives read addresses into the vector register file.
- Multiplies each returned element by a scalar latched at job start.
- Emits write strobes with write-back addresses.
- Tracks per-element and sticky overflow, with optional saturation.
- Sits between the vector register file and the vector-unit sequencer, which issues start and waits on done.

Parameters:
N_ELEM, 16, elements per vector; legal range 1..256.
IDX_W, $clog2(N_ELEM) (min 1), element index width; derived, not overridden.
SAT_EN, 0, 1 = an overflowing element is replaced by ±max finite (sign of the exact result); 0 = multiplier output passed through unchanged.

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
start  in  1  level job request; must stay high until done is seen; low mid-job = abort
scalar  in  16  FP16 scalar, sampled only on job acceptance
rd_idx  out  IDX_W  element read address to the register file (synchronous read, 1-cycle latency)
vecin  in  16  FP16 element for the rd_idx issued in the previous cycle
product  out  16  registered FP16 result
wr_idx  out  IDX_W  write-back address for product
write  out  1  product/wr_idx valid this cycle; one-cycle pulse per element
ov_elem  out  1  overflow flag for the element currently being written (qualified by write)
V  out  1  sticky overflow for the current or last job
busy  out  1  job in progress (RUN or DRAIN)
done  out  1  job complete; held high while start stays high

Behaviour:
Reset (asynchronous, Rst_n=0):
- State → IDLE.
- rd_idx, wr_idx, product = 0; write, ov_elem, V, busy, done = 0; latched scalar = 0.
- Applies mid-job too; no further writes after release until a new start.

States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → latch scalar, clear V, rd_idx=0, go RUN; busy=1 from the next cycle.
- RUN: each cycle issue rd_idx=i, i=0..N_ELEM-1. After issuing N_ELEM-1 → DRAIN; otherwise rd_idx+1.
- DRAIN: one cycle for the last element's data return → DONE.
- DONE: done=1, busy=0. start=0 → IDLE with done=0 next cycle. V is held until the next job is accepted.

Pipeline:
- rd_idx=i issued in cycle c; vecin valid during c+1; multiply is combinational in c+1.
- product, wr_idx=i, write=1, ov_elem registered at the edge ending c+1, so visible in c+2.
- Issue-to-write latency is 2 cycles; throughput is 1 element/cycle.
- Job of N_ELEM elements: start accepted at edge 0; writes visible cycles 2..N_ELEM+1; done visible cycle N_ELEM+2 (the cycle after the last write).

N_ELEM=1: RUN lasts one cycle, then DRAIN, DONE. Same timing rules.

Overflow:
- ov_elem = multiplier overflow for that element.
- V |= ov_elem on every write.
- SAT_EN=1 and ov_elem=1: product = 16'h7BFF if the sign is positive, 16'hFBFF if negative.

Scalar input changes after acceptance are ignored.

Abort (start=0 in RUN or DRAIN):
- Next cycle → IDLE. write forced 0 from that cycle, so no further writes, including in-flight ones.
- done never asserts. V keeps the value accumulated so far.

start=1 in DONE: stay in DONE; no re-trigger until start has been low for at least one cycle.

wr_idx and product hold their last values when write=0.

Decomposition:
Package smult_pkg:
- FP16_MAX_POS=16'h7BFF, FP16_MAX_NEG=16'hFBFF, FP16_ONE=16'h3C00.
- State enum {IDLE, RUN, DRAIN, DONE}.
Sub-module: reuse the existing VMULT combinational FP16 multiplier (product, Overflow) as the single instance. The saturation mux, pipeline registers and FSM are local.

Test Plan:
- N_ELEM=16, scalar=3C00, all vecin=3C00 → 16 writes, wr_idx 0..15 in order, product=3C00 each; done on cycle 18 after acceptance; V=0.
- scalar=BC00, vecin[i]=3C00 → every product=BC00. Then change the scalar input to 4000 mid-job → products remain BC00 (latched scalar).
- SAT_EN=0 then 1, scalar=7BFF, vecin[3]=4000, others 3C00 → element 3: ov_elem=1, product=7C00 (SAT_EN=0) / 7BFF (SAT_EN=1); V=1 sticky through DONE and IDLE; cleared on the next accepted start.
- Drop start after 5 issues → no writes after the abort cycle, done stays 0, state IDLE in 1 cycle; a new start re-runs cleanly from rd_idx=0.
- Pulse Rst_n low mid-RUN → all outputs 0 immediately (asynchronous); with start held high after release, a fresh job starts from rd_idx=0.
- N_ELEM=1, scalar=4000, vecin=3C00 → a single write of 4000 at wr_idx=0; done on cycle 3 after acceptance.
